// File: rtl/baud_generator_prog.sv
// Programmable NCO baud generator: oversample, baud and sample strobes from a
// phase accumulator, with rate changes deferred to the next bit boundary.
module baud_generator_prog #(
  parameter int          ACC_WIDTH  = 24,
  parameter int          OVERSAMPLE = 16,
  parameter int          SAMPLE_IDX = OVERSAMPLE / 2 - 1,
  parameter int unsigned RESET_INC  = 618475
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 resync,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic [ACC_WIDTH-1:0] inc_active,
  output logic                 tick_oversample,
  output logic                 tick_baud,
  output logic                 tick_sample
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [ACC_WIDTH-1:0] INC_RST = ACC_WIDTH'(RESET_INC);

  if (ACC_WIDTH < 8 || ACC_WIDTH > 32) begin : g_bad_acc_width
    $error("baud_generator_prog: ACC_WIDTH must be 8..32");
  end
  if (OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("baud_generator_prog: OVERSAMPLE must be even and >= 2");
  end
  if (SAMPLE_IDX < 0 || SAMPLE_IDX > OVERSAMPLE - 1) begin : g_bad_sample_idx
    $error("baud_generator_prog: SAMPLE_IDX must be 0..OVERSAMPLE-1");
  end
  if (RESET_INC == 0) begin : g_bad_reset_inc_zero
    $error("baud_generator_prog: RESET_INC must be nonzero");
  end
  if ((64'(RESET_INC) >> ACC_WIDTH) != 64'd0) begin : g_bad_reset_inc_range
    $error("baud_generator_prog: RESET_INC must be below 2**ACC_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  inc_q, inc_d;
  logic [ACC_WIDTH-1:0]  inc_pend_q, inc_pend_d;
  logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
  logic                  tick_os_q, tick_os_d;
  logic                  tick_baud_q, tick_baud_d;
  logic                  tick_sample_q, tick_sample_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [ACC_WIDTH:0]    sum;
  logic                  carry;
  logic                  os_last;
  logic                  hs;
  logic                  hs_ok;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    inc_d         = inc_q;
    inc_pend_d    = inc_pend_q;
    os_cnt_d      = os_cnt_q;
    tick_os_d     = 1'b0;
    tick_baud_d   = 1'b0;
    tick_sample_d = 1'b0;

    sum     = {1'b0, acc_q} + {1'b0, inc_q};
    carry   = sum[ACC_WIDTH];
    os_last = (os_cnt_q == OS_W'(OVERSAMPLE - 1));
    hs      = cfg_valid && (state_q != PEND);
    hs_ok   = hs && (cfg_inc != '0);
    // A zero increment is swallowed by the handshake and only reported.
    cfg_err_d = hs && (cfg_inc == '0);

    case (state_q)
      IDLE: begin
        acc_d    = '0;
        os_cnt_d = '0;
        if (hs_ok) inc_d = cfg_inc;
        if (enable) state_d = RUN;
      end
      RUN, PEND: begin
        if (!enable) begin
          acc_d    = '0;
          os_cnt_d = '0;
          state_d  = IDLE;
          if (state_q == PEND) inc_d = inc_pend_q;
          else if (hs_ok)      inc_d = cfg_inc;
        end else begin
          if (resync) begin
            acc_d    = '0;
            os_cnt_d = '0;
          end else begin
            acc_d = sum[ACC_WIDTH-1:0];
            if (carry) begin
              os_cnt_d      = os_last ? '0 : os_cnt_q + 1'b1;
              tick_os_d     = 1'b1;
              tick_baud_d   = os_last;
              tick_sample_d = (os_cnt_q == OS_W'(SAMPLE_IDX));
              // Swap rates exactly at the bit boundary so no bit is split.
              if (state_q == PEND && os_last) begin
                inc_d   = inc_pend_q;
                state_d = RUN;
              end
            end
          end
          if (state_q == RUN && hs_ok) begin
            inc_pend_d = cfg_inc;
            state_d    = PEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      inc_q         <= INC_RST;
      inc_pend_q    <= INC_RST;
      os_cnt_q      <= '0;
      tick_os_q     <= 1'b0;
      tick_baud_q   <= 1'b0;
      tick_sample_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      inc_q         <= inc_d;
      inc_pend_q    <= inc_pend_d;
      os_cnt_q      <= os_cnt_d;
      tick_os_q     <= tick_os_d;
      tick_baud_q   <= tick_baud_d;
      tick_sample_q <= tick_sample_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign cfg_ready       = (state_q != PEND);
  assign cfg_err         = cfg_err_q;
  assign inc_active      = inc_q;
  assign tick_oversample = tick_os_q;
  assign tick_baud       = tick_baud_q;
  assign tick_sample     = tick_sample_q;

endmodule

// File: tb/tb_baud_generator_prog.sv
// Directed testbench for baud_generator_prog with an 8-bit accumulator,
// 4x oversampling, sample index 1 and reset increment 64.
module tb_baud_generator_prog;

  localparam int AW = 8;

  typedef struct {
    logic          enable;
    logic          resync;
    logic          cfg_valid;
    logic [AW-1:0] cfg_inc;
    logic          exp_os;
    logic          exp_baud;
    logic          exp_sample;
    logic          exp_ready;
    logic          exp_err;
    logic [AW-1:0] exp_inc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          resync;
  logic [AW-1:0] cfg_inc;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_err;
  logic [AW-1:0] inc_active;
  logic          tick_oversample;
  logic          tick_baud;
  logic          tick_sample;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t table_v[38];

  baud_generator_prog #(
    .ACC_WIDTH (AW),
    .OVERSAMPLE(4),
    .SAMPLE_IDX(1),
    .RESET_INC (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .resync         (resync),
    .cfg_inc        (cfg_inc),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_err        (cfg_err),
    .inc_active     (inc_active),
    .tick_oversample(tick_oversample),
    .tick_baud      (tick_baud),
    .tick_sample    (tick_sample)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected strobe is seen; n is the number of edges taken.
  task automatic wait_tick(input int sel, input int budget, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      step();
      n++;
      hit = (sel == 0) ? tick_oversample : (sel == 1) ? tick_baud : tick_sample;
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL timeout sel=%0d: got no tick, expected one within %0d cycles", sel, budget);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    enable    = v.enable;
    resync    = v.resync;
    cfg_valid = v.cfg_valid;
    cfg_inc   = v.cfg_inc;
  endtask

  initial begin
    int n;
    int ticks;

    rst_n = 1'b0; enable = 1'b0; resync = 1'b0; cfg_valid = 1'b0; cfg_inc = '0;

    // Free-running pattern at inc=64: carry every 4 edges, sample on os 1, baud on os 3.
    for (int k = 0; k < 38; k++) begin
      table_v[k] = '{enable: 1'b1, resync: 1'b0, cfg_valid: 1'b0, cfg_inc: 8'd0,
                     exp_os: (k > 0 && k % 4 == 0), exp_baud: (k > 0 && k % 16 == 0),
                     exp_sample: (k % 16 == 8), exp_ready: 1'b1, exp_err: 1'b0,
                     exp_inc: 8'd64};
    end
    table_v[34].cfg_valid = 1'b1;
    table_v[34].exp_err   = 1'b1;

    #12;
    check_output("rst_tick_os", tick_oversample, 0);
    check_output("rst_tick_baud", tick_baud, 0);
    check_output("rst_tick_sample", tick_sample, 0);
    check_output("rst_cfg_err", cfg_err, 0);
    check_output("rst_cfg_ready", cfg_ready, 1);
    check_output("rst_inc_active", inc_active, 64);

    step();
    rst_n = 1'b1;

    for (int i = 0; i < 38; i++) begin
      apply_stimulus(table_v[i]);
      step();
      check_output($sformatf("vec%0d_tick_os", i), tick_oversample, table_v[i].exp_os);
      check_output($sformatf("vec%0d_tick_baud", i), tick_baud, table_v[i].exp_baud);
      check_output($sformatf("vec%0d_tick_sample", i), tick_sample, table_v[i].exp_sample);
      check_output($sformatf("vec%0d_cfg_ready", i), cfg_ready, table_v[i].exp_ready);
      check_output($sformatf("vec%0d_cfg_err", i), cfg_err, table_v[i].exp_err);
      check_output($sformatf("vec%0d_inc_active", i), inc_active, table_v[i].exp_inc);
    end
    cfg_valid = 1'b0;

    // Resync two cycles after an oversample tick restarts the bit.
    wait_tick(0, 10, n);
    step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check_output("resync_no_tick", tick_oversample, 0);
    wait_tick(0, 10, n);
    check_output("resync_os_dist", n, 4);
    wait_tick(1, 30, n);
    check_output("resync_baud_dist", n, 12);

    // Resync landing on a carry edge must swallow that tick.
    step(); step(); step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check_output("resync_carry_os", tick_oversample, 0);
    check_output("resync_carry_sample", tick_sample, 0);
    wait_tick(0, 10, n);
    check_output("resync_carry_os_dist", n, 4);

    // Rate change to 128 offered mid-bit takes effect at the next bit boundary.
    wait_tick(1, 40, n);
    step(); step();
    cfg_valid = 1'b1; cfg_inc = 8'd128;
    step();
    cfg_valid = 1'b0;
    check_output("pend_ready_low", cfg_ready, 0);
    check_output("pend_inc_unchanged", inc_active, 64);
    ticks = 0;
    n = 0;
    while (!tick_baud && n < 40) begin
      step();
      n++;
      if (!tick_baud && cfg_ready) ticks++;
    end
    check_output("pend_baud_dist", n, 13);
    check_output("pend_ready_early", ticks, 0);
    check_output("pend_ready_back", cfg_ready, 1);
    check_output("pend_inc_applied", inc_active, 128);
    wait_tick(0, 10, n);
    check_output("fast_os_dist1", n, 2);
    wait_tick(0, 10, n);
    check_output("fast_os_dist2", n, 2);

    // Dropping enable in PEND applies the pending 32 and idles.
    cfg_valid = 1'b1; cfg_inc = 8'd32;
    step();
    cfg_valid = 1'b0;
    check_output("pend32_ready", cfg_ready, 0);
    enable = 1'b0;
    step();
    check_output("idle_ready", cfg_ready, 1);
    check_output("idle_inc", inc_active, 32);
    check_output("idle_tick_os", tick_oversample, 0);
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tick_oversample || tick_baud || tick_sample) ticks++;
    end
    check_output("idle_quiet", ticks, 0);
    enable = 1'b1;
    wait_tick(0, 20, n);
    check_output("slow_first_os", n, 9);
    wait_tick(0, 20, n);
    check_output("slow_os_dist", n, 8);

    // Reset during a tick with 128 pending discards the pending rate.
    cfg_valid = 1'b1; cfg_inc = 8'd128;
    step();
    cfg_valid = 1'b0;
    check_output("pend128_ready", cfg_ready, 0);
    wait_tick(0, 20, n);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_tick_os", tick_oversample, 0);
    check_output("midrst_tick_baud", tick_baud, 0);
    check_output("midrst_tick_sample", tick_sample, 0);
    check_output("midrst_cfg_ready", cfg_ready, 1);
    check_output("midrst_inc", inc_active, 64);
    step();
    rst_n = 1'b1;
    wait_tick(0, 20, n);
    check_output("post_rst_first_os", n, 5);
    wait_tick(0, 20, n);
    check_output("post_rst_os_dist", n, 4);
    check_output("post_rst_inc", inc_active, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_generator_prog.md
BAUD_GENERATOR_PROG -- requirements
Module: baud_generator_prog

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 24: NCO phase accumulator width in bits, legal 8..32.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: ticks per bit, even and >= 2.
REQ-003 SHALL have parameter SAMPLE_IDX, default OVERSAMPLE/2-1: oversample index at which tick_sample fires, legal 0..OVERSAMPLE-1.
REQ-004 SHALL have parameter RESET_INC, default 618475: increment loaded at reset, i.e. 115200 baud x16 at 50 MHz.
REQ-005 SHALL have parameter checks that raise elaboration errors for illegal ACC_WIDTH, OVERSAMPLE or SAMPLE_IDX, for RESET_INC==0, and for RESET_INC >= 2^ACC_WIDTH.
REQ-006 clk  in  1  sole clock, all state on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  when 1, the generator runs; when 0, it is idle.
REQ-009 resync  in  1  restarts phase; the RX asserts it for 1 cycle on start-bit edge.
REQ-010 cfg_inc  in  ACC_WIDTH  new phase increment.
REQ-011 cfg_valid  in  1  new increment offered.
REQ-012 cfg_ready  out  1  increment can be accepted.
REQ-013 cfg_err  out  1  1-cycle pulse when a zero increment is rejected.
REQ-014 inc_active  out  ACC_WIDTH  increment currently driving the accumulator.
REQ-015 tick_oversample  out  1  1-cycle strobe at BAUD*OVERSAMPLE.
REQ-016 tick_baud  out  1  1-cycle strobe once per bit.
REQ-017 tick_sample  out  1  1-cycle strobe at SAMPLE_IDX within each bit.

Function
REQ-018 SHALL keep an ACC_WIDTH-bit accumulator acc, an increment register inc, a pending register inc_pend and an oversample counter os_cnt of width $clog2(OVERSAMPLE).
REQ-019 SHALL have a state machine with states IDLE, RUN and PEND, all registered.
REQ-020 In RUN or PEND, SHALL compute sum = acc + inc in ACC_WIDTH+1 bits each cycle, with acc <= sum[ACC_WIDTH-1:0] and carry = sum[ACC_WIDTH].
REQ-021 On the cycle after a carry, SHALL assert tick_oversample for exactly 1 cycle; all ticks are registered with 1-cycle latency from the carry edge.
REQ-022 On each carry, SHALL wrap os_cnt to 0 if it equals OVERSAMPLE-1, else increment it.
REQ-023 SHALL assert tick_baud together with tick_oversample when the pre-increment os_cnt equals OVERSAMPLE-1.
REQ-024 SHALL assert tick_sample together with tick_oversample when the pre-increment os_cnt equals SAMPLE_IDX.
REQ-025 IDLE: acc and os_cnt are held at 0, no ticks; enable=1 moves to RUN on the next cycle.
REQ-026 RUN: enable=0 moves to IDLE, clears acc and os_cnt, and suppresses any tick on that edge.
REQ-027 cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND.
REQ-028 A handshake (cfg_valid & cfg_ready) with cfg_inc==0 SHALL be consumed, pulse cfg_err the next cycle, and change no state.
REQ-029 Handshake in IDLE with nonzero cfg_inc: inc <= cfg_inc immediately.
REQ-030 Handshake in RUN with nonzero cfg_inc: inc_pend <= cfg_inc and the state goes to PEND.
REQ-031 PEND: on the carry edge that produces tick_baud, inc <= inc_pend and the state returns to RUN; the new rate starts on the next bit boundary with no partial bit.
REQ-032 PEND: enable=0 applies inc_pend immediately and goes to IDLE.
REQ-033 resync=1 in RUN or PEND: on the same edge, acc <= 0 and os_cnt <= 0, and no tick is issued for that edge.
REQ-034 resync in PEND: the pending increment stays pending.
REQ-035 resync SHALL be ignored in IDLE.
REQ-036 Simultaneous enable=0 and resync: enable=0 SHALL win.
REQ-037 Simultaneous handshake and resync in RUN: both SHALL take effect.
REQ-038 inc_active SHALL equal inc at all times.
REQ-039 Accumulator wrap-around SHALL be modulo 2^ACC_WIDTH; no saturation.

Reset
REQ-040 While rst_n=0, SHALL force acc=0, os_cnt=0, inc=RESET_INC, inc_pend=RESET_INC, state=IDLE.
REQ-041 While rst_n=0, SHALL force tick_oversample=0, tick_baud=0, tick_sample=0 and cfg_err=0; cfg_ready=1 and inc_active=RESET_INC.
REQ-042 Reset asserted mid-operation SHALL discard a pending increment.
REQ-043 After rst_n deasserts, the first tick SHALL occur no earlier than the second cycle after enable=1 is sampled.

Verification (bench: ACC_WIDTH=8, OVERSAMPLE=4, SAMPLE_IDX=1, RESET_INC=64)
REQ-044 Reset, then enable=1 held: tick_oversample every 4 cycles, tick_baud every 16 cycles, tick_sample 8 cycles after each tick_baud (2nd oversample tick of each bit).
REQ-045 In RUN, send cfg_inc=128 mid-bit: cfg_ready=0 until the next tick_baud, then tick_oversample spaced 2 cycles, inc_active=128.
REQ-046 Send cfg_inc=0: cfg_err pulses 1 cycle, inc_active unchanged at 64, state unchanged.
REQ-047 Pulse resync 2 cycles after a tick_oversample: no tick on that edge, next tick_oversample 4 cycles after resync, next tick_baud 16 cycles after resync.
REQ-048 Drop enable in PEND with pending 32: IDLE with no ticks, inc_active=32; re-enable gives tick_oversample every 8 cycles.
REQ-049 Assert rst_n=0 mid-bit with 128 pending: all ticks 0 immediately, inc_active=64 after reset.
